// File: rtl/start_sequencer_pkg.sv
// Shared types and constants for the start sequencer and its edge detector.
// START_TIMEOUT_EN (in the top) enables the done watchdog.
package start_sequencer_pkg;

   localparam logic BIT_ZERO = 1'b0;
   localparam logic BIT_ONE  = 1'b1;

   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PULSE,
      S_WAIT_DONE,
      S_WAIT_RELEASE,
      S_ERROR
   } state_t;

endpackage

// File: rtl/start_sequencer_rise_edge_detect.sv
// Rising-edge detector on a debounced level; the reset value of the history
// register decides whether a level held through reset counts as an edge.
module rise_edge_detect
   import start_sequencer_pkg::*;
#(
   parameter logic PREV_RST = BIT_ONE
) (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev <= PREV_RST;
      end else begin
         prev <= sig;
      end
   end

   assign rise = sig & ~prev;

endmodule

// File: rtl/start_sequencer.sv
// Turns a debounced button into one start pulse per press, gated by datapath busy.
// Define START_TIMEOUT_EN to add the done watchdog, ERROR state and error port.
module start_sequencer
  import start_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic db_in,
  input  logic done,
  output logic start_pulse,
  output logic busy,
  output logic ready
`ifdef START_TIMEOUT_EN
  ,
  output logic error
`endif
);

  state_t state;
  logic   rise;

  // History resets high so a button held through reset never launches a start.
  rise_edge_detect #(
    .PREV_RST(BIT_ONE)
  ) u_rise (
    .clk (clk),
    .rst (rst),
    .sig (db_in),
    .rise(rise)
  );

`ifdef START_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             timed_out;

  assign timed_out = (state == S_WAIT_DONE) && (wd_cnt == TERM_CNT);
`endif

  // Outputs are registered alongside the state, so each branch sets the
  // values that belong to the state it is entering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      start_pulse <= BIT_ZERO;
      busy        <= BIT_ZERO;
      ready       <= BIT_ONE;
`ifdef START_TIMEOUT_EN
      error       <= BIT_ZERO;
      wd_cnt      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (rise) begin
            state       <= S_PULSE;
            start_pulse <= BIT_ONE;
            busy        <= BIT_ONE;
            ready       <= BIT_ZERO;
          end
        end

        // done during the pulse cycle completes the job just like WAIT_DONE.
        S_PULSE, S_WAIT_DONE: begin
          start_pulse <= BIT_ZERO;
          if (done) begin
            busy <= BIT_ZERO;
            if (db_in) begin
              state <= S_WAIT_RELEASE;
              ready <= BIT_ZERO;
            end else begin
              state <= S_IDLE;
              ready <= BIT_ONE;
            end
          end
`ifdef START_TIMEOUT_EN
          else if (timed_out) begin
            state <= S_ERROR;
            busy  <= BIT_ZERO;
            ready <= BIT_ZERO;
            error <= BIT_ONE;
          end
`endif
          else begin
            state <= S_WAIT_DONE;
`ifdef START_TIMEOUT_EN
            wd_cnt <= (state == S_PULSE) ? '0 : wd_cnt + CNT_W'(1);
`endif
          end
        end

        S_WAIT_RELEASE: begin
          if (!db_in) begin
            state <= S_IDLE;
            ready <= BIT_ONE;
          end
        end

`ifdef START_TIMEOUT_EN
        // A fresh press retries the job; done is meaningless here.
        S_ERROR: begin
          if (rise) begin
            state       <= S_PULSE;
            start_pulse <= BIT_ONE;
            busy        <= BIT_ONE;
            error       <= BIT_ZERO;
          end
        end
`endif

        default: begin
          state       <= S_IDLE;
          start_pulse <= BIT_ZERO;
          busy        <= BIT_ZERO;
          ready       <= BIT_ONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_start_sequencer.sv
// Scoreboard bench for start_sequencer: directed press scenarios plus random
// button/done/reset traffic checked cycle by cycle against a job-level model.
module tb_start_sequencer;

  localparam int TIMEOUT = 8;
`ifdef START_TIMEOUT_EN
  localparam int HOLD3 = 6;
`else
  localparam int HOLD3 = 30;
`endif

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic db_in = 1'b0;
  logic done  = 1'b0;
  logic start_pulse;
  logic busy;
  logic ready;
  logic error_obs;

`ifdef START_TIMEOUT_EN
  logic error;
  assign error_obs = error;
`else
  assign error_obs = 1'b0;
`endif

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  start_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .db_in      (db_in),
    .done       (done),
    .start_pulse(start_pulse),
    .busy       (busy),
    .ready      (ready)
`ifdef START_TIMEOUT_EN
    ,
    .error      (error)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  // Reference model in job terms: a job is open from the start strobe until
  // done is accepted; after that the button may still need releasing.
  bit m_prev = 1'b1;
  bit m_job  = 1'b0;
  bit m_just = 1'b0;
  bit m_hold = 1'b0;
  bit m_err  = 1'b0;
  int m_age  = 0;

  task automatic model_step(input logic db, input logic dn, input logic r);
    bit rise_m;
    if (r) begin
      m_prev = 1'b1;
      m_job  = 1'b0;
      m_just = 1'b0;
      m_hold = 1'b0;
      m_err  = 1'b0;
      m_age  = 0;
      return;
    end
    rise_m = db && !m_prev;
    m_prev = db;
    if (m_job) begin
      if (dn) begin
        m_job  = 1'b0;
        m_just = 1'b0;
        m_hold = db;
      end else if (m_just) begin
        m_just = 1'b0;
        m_age  = 0;
      end else begin
        m_age++;
`ifdef START_TIMEOUT_EN
        if (m_age >= TIMEOUT) begin
          m_job = 1'b0;
          m_err = 1'b1;
        end
`endif
      end
    end else if (m_hold) begin
      if (!db) m_hold = 1'b0;
    end else if (rise_m) begin
      m_job  = 1'b1;
      m_just = 1'b1;
      m_err  = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic db, input logic dn, input logic r);
    logic [3:0] e;
    db_in = db;
    done  = dn;
    rst   = r;
    model_step(db, dn, r);
    e = {m_just, m_job, ~m_job & ~m_hold & ~m_err, m_err};
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic monitor_loop();
    logic [3:0] act;
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {start_pulse, busy, ready, error_obs};
        n_checks++;
        if (act !== e) begin
          n_errors++;
          $display("FAIL outputs t=%0t: got pulse/busy/ready/error=%b expected %b",
                   $time, act, e);
        end
        if (start_pulse === 1'b1) n_pulses++;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   base;
    logic rdb;
    logic rdn;
    logic rr;

    fork
      monitor_loop();
    join_none
    #1;

    // Press held 50 cycles, done 10 cycles in, then release.
    repeat (2) step(1'b0, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    settle();
    base = n_pulses;
    for (int i = 0; i < 50; i++) step(1'b1, (i == 10), 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    settle();
    check_eq("s1 pulses", n_pulses - base, 1);
    check_eq("s1 ready after release", int'(ready), 1);

    // Button held through reset: no start until released and pressed again.
    repeat (3) step(1'b1, 1'b0, 1'b1);
    settle();
    base = n_pulses;
    repeat (20) step(1'b1, 1'b0, 1'b0);
    settle();
    check_eq("s2 held through reset", n_pulses - base, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    settle();
    check_eq("s2 fresh press", n_pulses - base, 1);

    // Extra presses while busy are dropped; held button after done gives nothing.
    repeat (2) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    settle();
    base = n_pulses;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < HOLD3; i++) step(((i / 2) % 2) == 1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    settle();
    check_eq("s3 presses while busy", n_pulses - base, 1);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    settle();
    check_eq("s3 press after release", n_pulses - base, 2);

    // done coincident with the start strobe, button already released.
    repeat (2) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    settle();
    base = n_pulses;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    settle();
    check_eq("s4 pulses", n_pulses - base, 1);
    check_eq("s4 ready", int'(ready), 1);

`ifdef START_TIMEOUT_EN
    // done never comes: watchdog trips, next press retries.
    repeat (2) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    settle();
    base = n_pulses;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    settle();
    check_eq("s5 error set", int'(error), 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    settle();
    check_eq("s5 retry pulses", n_pulses - base, 2);
    check_eq("s5 error cleared", int'(error), 0);

    // done on the terminal-count cycle wins over the watchdog.
    repeat (2) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (TIMEOUT - 1) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    settle();
    check_eq("s6 no error", int'(error), 0);
    check_eq("s6 ready", int'(ready), 1);
`endif

    // Random button, done and occasional reset traffic.
    repeat (2) step(1'b0, 1'b0, 1'b1);
    rdb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rdb = ~rdb;
      rdn = ($urandom_range(0, 9) == 0);
      rr  = ($urandom_range(0, 299) == 0);
      step(rdb, rdn, rr);
    end
    settle();
    check_eq("queue drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
